// File: rtl/hdmi_cfg_seq_if.sv
// HDMI config sequencer I2C write-request bundle (sequencer side = master).
// Latency: wires only; the sequencer drives the request fields from registers.
// Backpressure: the sequencer holds i2c_req and the fields until the I2C engine pulses i2c_done.
//
// Ports (signals):
//   i2c_req    : write request, high for the whole transaction
//   i2c_dev    : 7-bit device address
//   i2c_reg    : register address byte
//   i2c_wdata  : register value byte
//   i2c_done   : single-cycle completion pulse from the I2C engine
//   i2c_nack   : qualifies i2c_done; 1 = device NACKed
interface hdmi_cfg_seq_if;
    logic       i2c_req;
    logic [6:0] i2c_dev;
    logic [7:0] i2c_reg;
    logic [7:0] i2c_wdata;
    logic       i2c_done;
    logic       i2c_nack;

    modport master (
        output i2c_req, i2c_dev, i2c_reg, i2c_wdata,
        input  i2c_done, i2c_nack
    );

    modport slave (
        input  i2c_req, i2c_dev, i2c_reg, i2c_wdata,
        output i2c_done, i2c_nack
    );
endinterface

// File: rtl/hdmi_cfg_seq.sv
// Walks a config ROM and writes each {reg,val} entry to an HDMI transmitter over I2C, with NACK retries.
// Latency: PWRUP_CYCLES wait, then FETCH/LATCH (2 cycles) before each request; RETRY_GAP idle before a retry.
// Backpressure: one outstanding request; the sequencer stalls in ISSUE until i2c_done.
//
// Ports:
//   sys0_clk, sys0_rstn : clock and synchronous active-low reset
//   start, hpd          : re-sequence pulse and synchronous hot-plug level
//   tbl_addr, tbl_data  : ROM read address / data (data valid one cycle after address)
//   i2c                 : I2C write-request bundle (master modport)
//   busy, done, error   : status; err_index holds the index of the entry that exhausted its retries
module hdmi_cfg_seq #(
    parameter logic [6:0] DEV_ADDR     = 7'h39,
    parameter int         NUM_REGS     = 16,
    parameter int         PWRUP_CYCLES = 200000,
    parameter int         MAX_RETRY    = 3,
    parameter int         RETRY_GAP    = 1000
) (
    input  logic           sys0_clk,
    input  logic           sys0_rstn,
    input  logic           start,
    input  logic           hpd,
    output logic [7:0]     tbl_addr,
    input  logic [15:0]    tbl_data,
    hdmi_cfg_seq_if.master i2c,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [7:0]     err_index
);

    // One down-counter serves both the power-up wait and the retry gap.
    localparam int CNT_MAX = (PWRUP_CYCLES > RETRY_GAP) ? PWRUP_CYCLES : RETRY_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(RETRY_GAP - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT  = RTY_W'(MAX_RETRY);
    localparam logic [7:0]       LAST_IDX   = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT, FETCH, LATCH, ISSUE, RETRY, DONE, ERROR
    } state_t;

    state_t           state, state_d;
    logic [7:0]       idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [RTY_W-1:0] rty, rty_d;
    logic             pend, pend_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       eidx, eidx_d;
    logic             restart_now;

    // hpd history tracks the pin even during reset, so a level that is
    // already high when reset releases is not mistaken for a plug-in.
    logic hpd_q;
    logic hpd_rise;
    logic hpd_fall;
    logic restart_evt;

    always_ff @(posedge sys0_clk) begin
        hpd_q <= hpd;
    end

    assign hpd_rise    = hpd & ~hpd_q;
    assign hpd_fall    = ~hpd & hpd_q;
    // start and a plug-in in the same cycle collapse into a single restart.
    assign restart_evt = start | hpd_rise;

    always_ff @(posedge sys0_clk) begin
        if (!sys0_rstn) begin
            state   <= WAIT;
            idx     <= '0;
            cnt     <= PWRUP_LOAD;
            rty     <= '0;
            pend    <= 1'b0;
            reg_q   <= '0;
            wdata_q <= '0;
            eidx    <= '0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            cnt     <= cnt_d;
            rty     <= rty_d;
            pend    <= pend_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            eidx    <= eidx_d;
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        cnt_d       = cnt;
        rty_d       = rty;
        pend_d      = pend;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        eidx_d      = eidx;
        restart_now = 1'b0;

        case (state)
            IDLE: begin
                restart_now = restart_evt;
            end
            DONE, ERROR: begin
                restart_now = restart_evt;
                if (hpd_fall) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                restart_now = restart_evt | pend;
                if (cnt == '0) begin
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            FETCH: begin
                // tbl_addr already presents idx; the ROM answers next cycle.
                restart_now = restart_evt | pend;
                state_d     = LATCH;
            end
            LATCH: begin
                restart_now = restart_evt | pend;
                reg_d       = tbl_data[15:8];
                wdata_d     = tbl_data[7:0];
                rty_d       = '0;
                state_d     = ISSUE;
            end
            ISSUE: begin
                // A bus transaction is never abandoned: a restart seen here
                // waits for i2c_done and then wins over ACK/NACK handling.
                if (restart_evt) begin
                    pend_d = 1'b1;
                end
                if (i2c.i2c_done) begin
                    if (pend || restart_evt) begin
                        restart_now = 1'b1;
                    end else if (!i2c.i2c_nack) begin
                        if (idx == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx + 8'd1;
                            state_d = FETCH;
                        end
                    end else if (rty < RTY_LIMIT) begin
                        rty_d   = rty + 1'b1;
                        cnt_d   = GAP_LOAD;
                        state_d = RETRY;
                    end else begin
                        eidx_d  = idx;
                        state_d = ERROR;
                    end
                end
            end
            RETRY: begin
                restart_now = restart_evt | pend;
                if (cnt == '0) begin
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                state_d = WAIT;
            end
        endcase

        if (restart_now) begin
            state_d = WAIT;
            idx_d   = '0;
            cnt_d   = PWRUP_LOAD;
            rty_d   = '0;
            pend_d  = 1'b0;
            eidx_d  = '0;
        end
    end

    assign tbl_addr      = idx;
    assign i2c.i2c_req   = (state == ISSUE);
    assign i2c.i2c_dev   = DEV_ADDR;
    assign i2c.i2c_reg   = reg_q;
    assign i2c.i2c_wdata = wdata_q;

    assign busy      = state inside {WAIT, FETCH, LATCH, ISSUE, RETRY};
    assign done      = (state == DONE);
    assign error     = (state == ERROR);
    assign err_index = eidx;

endmodule
